// File: rtl/sgd_rd_pkg.sv
// rtl/sgd_rd_pkg.sv - tags, constants and issuer state shared by the SGD read-command arbiter
package sgd_rd_pkg;

  localparam logic [7:0] MEM_RD_A_TAG = 8'h0a;
  localparam logic [7:0] MEM_RD_B_TAG = 8'h0b;
  localparam int CL_BYTES = 64;
  localparam int DEF_MAX_BURST_BYTES = 4096;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } issue_state_t;

  // Region lengths are only honoured in whole cache lines.
  function automatic logic [31:0] cl_floor(input logic [31:0] len);
    return len & ~32'(CL_BYTES - 1);
  endfunction

endpackage

// File: rtl/sgd_tag_fifo.sv
// rtl/sgd_tag_fifo.sv - synchronous tag FIFO recording the source of each outstanding burst
module sgd_tag_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sgd_rd_cmd_arbiter.sv
// rtl/sgd_rd_cmd_arbiter.sv - round-robin A/B region reader sharing one memory read-command channel
module sgd_rd_cmd_arbiter
  import sgd_rd_pkg::*;
#(
  parameter int MAX_BURST_BYTES = DEF_MAX_BURST_BYTES,
  parameter int TAG_FIFO_DEPTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              a_cmd_valid,
  output logic                              a_cmd_ready,
  input  logic [63:0]                       a_cmd_address,
  input  logic [31:0]                       a_cmd_length,
  input  logic                              b_cmd_valid,
  output logic                              b_cmd_ready,
  input  logic [63:0]                       b_cmd_address,
  input  logic [31:0]                       b_cmd_length,
  output logic                              m_cmd_valid,
  input  logic                              m_cmd_ready,
  output logic [63:0]                       m_cmd_address,
  output logic [31:0]                       m_cmd_length,
  input  logic                              m_rd_data_tvalid,
  output logic                              m_rd_data_tready,
  input  logic [511:0]                      m_rd_data_tdata,
  input  logic [63:0]                       m_rd_data_tkeep,
  input  logic                              m_rd_data_tlast,
  output logic                              a_rd_data_tvalid,
  input  logic                              a_rd_data_tready,
  output logic [511:0]                      a_rd_data_tdata,
  output logic [63:0]                       a_rd_data_tkeep,
  output logic                              a_rd_data_tlast,
  output logic                              b_rd_data_tvalid,
  input  logic                              b_rd_data_tready,
  output logic [511:0]                      b_rd_data_tdata,
  output logic [63:0]                       b_rd_data_tkeep,
  output logic                              b_rd_data_tlast,
  output logic [$clog2(TAG_FIFO_DEPTH):0]   outstanding,
  output logic                              err_len
);

  localparam logic [31:0] MAX_LEN = 32'(MAX_BURST_BYTES);

  issue_state_t state;
  logic [63:0]  cur_addr;
  logic [31:0]  remaining;
  logic [7:0]   cur_tag;
  logic         last_b;

  logic         grant_a;
  logic         grant_b;
  logic [31:0]  req_len;
  logic [31:0]  req_floor;
  logic [31:0]  burst_len;
  logic         cmd_fire;

  logic [7:0]   head_tag;
  logic         fifo_full;
  logic         fifo_empty;
  logic         route_a;
  logic         route_b;
  logic         beat_pop;

  // Contention goes to whichever side was not served last; reset leaves B as "last".
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == ST_IDLE) begin
      if (a_cmd_valid && (!b_cmd_valid || last_b)) grant_a = 1'b1;
      else if (b_cmd_valid)                        grant_b = 1'b1;
    end
  end

  assign a_cmd_ready   = grant_a;
  assign b_cmd_ready   = grant_b;
  assign req_len       = grant_b ? b_cmd_length : a_cmd_length;
  assign req_floor     = cl_floor(req_len);
  assign burst_len     = (remaining > MAX_LEN) ? MAX_LEN : remaining;
  assign m_cmd_valid   = (state == ST_ISSUE) && !fifo_full;
  assign m_cmd_address = cur_addr;
  assign m_cmd_length  = burst_len;
  assign cmd_fire      = m_cmd_valid && m_cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      cur_tag   <= MEM_RD_A_TAG;
      last_b    <= 1'b1;
      err_len   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_a || grant_b) begin
            last_b    <= grant_b;
            cur_addr  <= grant_b ? b_cmd_address : a_cmd_address;
            remaining <= req_floor;
            cur_tag   <= grant_b ? MEM_RD_B_TAG : MEM_RD_A_TAG;
            if ((req_len & 32'(CL_BYTES - 1)) != '0) err_len <= 1'b1;
            if (req_floor != '0) state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cmd_fire) begin
            cur_addr  <= cur_addr + 64'(burst_len);
            remaining <= remaining - burst_len;
            if (remaining == burst_len) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sgd_tag_fifo #(
    .DEPTH (TAG_FIFO_DEPTH),
    .W     (8)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_fire),
    .push_data (cur_tag),
    .pop       (beat_pop),
    .head      (head_tag),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstanding)
  );

  // Read data is steered purely by the oldest outstanding tag, with no pipeline stage.
  assign route_a          = !fifo_empty && (head_tag == MEM_RD_A_TAG);
  assign route_b          = !fifo_empty && (head_tag != MEM_RD_A_TAG);
  assign m_rd_data_tready = (route_a && a_rd_data_tready) || (route_b && b_rd_data_tready);
  assign beat_pop         = m_rd_data_tvalid && m_rd_data_tready && m_rd_data_tlast;

  assign a_rd_data_tvalid = route_a && m_rd_data_tvalid;
  assign a_rd_data_tdata  = m_rd_data_tdata;
  assign a_rd_data_tkeep  = m_rd_data_tkeep;
  assign a_rd_data_tlast  = m_rd_data_tlast;
  assign b_rd_data_tvalid = route_b && m_rd_data_tvalid;
  assign b_rd_data_tdata  = m_rd_data_tdata;
  assign b_rd_data_tkeep  = m_rd_data_tkeep;
  assign b_rd_data_tlast  = m_rd_data_tlast;

endmodule

// File: tb/tb_sgd_rd_cmd_arbiter.sv
// tb/tb_sgd_rd_cmd_arbiter.sv - bench for sgd_rd_cmd_arbiter: vector table, corner sequences, random run
`timescale 1ns/1ps
module tb_sgd_rd_cmd_arbiter;

  localparam int MAXB  = 4096;
  localparam int DEPTH = 16;
  localparam logic [7:0] TAG_A = 8'h0a;
  localparam logic [7:0] TAG_B = 8'h0b;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic a_cmd_valid, a_cmd_ready, b_cmd_valid, b_cmd_ready, m_cmd_valid, m_cmd_ready;
  logic [63:0] a_cmd_address, b_cmd_address, m_cmd_address;
  logic [31:0] a_cmd_length, b_cmd_length, m_cmd_length;
  logic m_rd_data_tvalid, m_rd_data_tready, m_rd_data_tlast;
  logic [511:0] m_rd_data_tdata, a_rd_data_tdata, b_rd_data_tdata;
  logic [63:0] m_rd_data_tkeep, a_rd_data_tkeep, b_rd_data_tkeep;
  logic a_rd_data_tvalid, a_rd_data_tready, a_rd_data_tlast;
  logic b_rd_data_tvalid, b_rd_data_tready, b_rd_data_tlast;
  logic [4:0] outstanding;
  logic err_len;

  sgd_rd_cmd_arbiter #(.MAX_BURST_BYTES(MAXB), .TAG_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_cmd_valid(a_cmd_valid), .a_cmd_ready(a_cmd_ready),
    .a_cmd_address(a_cmd_address), .a_cmd_length(a_cmd_length),
    .b_cmd_valid(b_cmd_valid), .b_cmd_ready(b_cmd_ready),
    .b_cmd_address(b_cmd_address), .b_cmd_length(b_cmd_length),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_cmd_address(m_cmd_address), .m_cmd_length(m_cmd_length),
    .m_rd_data_tvalid(m_rd_data_tvalid), .m_rd_data_tready(m_rd_data_tready),
    .m_rd_data_tdata(m_rd_data_tdata), .m_rd_data_tkeep(m_rd_data_tkeep),
    .m_rd_data_tlast(m_rd_data_tlast),
    .a_rd_data_tvalid(a_rd_data_tvalid), .a_rd_data_tready(a_rd_data_tready),
    .a_rd_data_tdata(a_rd_data_tdata), .a_rd_data_tkeep(a_rd_data_tkeep),
    .a_rd_data_tlast(a_rd_data_tlast),
    .b_rd_data_tvalid(b_rd_data_tvalid), .b_rd_data_tready(b_rd_data_tready),
    .b_rd_data_tdata(b_rd_data_tdata), .b_rd_data_tkeep(b_rd_data_tkeep),
    .b_rd_data_tlast(b_rd_data_tlast),
    .outstanding(outstanding), .err_len(err_len)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_b(input string name, input logic got, input logic exp);
    chk(name, 64'(got), 64'(exp));
  endtask

  // Reference model: pending bursts of the region being issued, tags of issued bursts.
  typedef struct {
    logic [63:0] addr;
    logic [31:0] len;
    logic [7:0]  tag;
  } burst_t;

  burst_t     exp_q[$];
  logic [7:0] tag_q[$];
  bit         mdl_last_b;
  bit         mdl_err;
  bit         mdl_acc_a, mdl_acc_b, mdl_m_fire;

  // Observations of the DUT, compared against hand-written constants.
  int           obs_n;
  logic [63:0]  obs_first_addr, obs_last_addr;
  logic [31:0]  obs_first_len, obs_last_len;
  logic [511:0] a_rx[$];
  logic [511:0] b_rx[$];

  function automatic void model_reset();
    exp_q.delete();
    tag_q.delete();
    mdl_last_b = 1'b1;
    mdl_err    = 1'b0;
  endfunction

  function automatic void model_accept(input logic [63:0] addr, input logic [31:0] len,
                                       input logic [7:0] tag);
    logic [31:0] r;
    burst_t b;
    if (len % 64 != 0) mdl_err = 1'b1;
    r = len - (len % 64);
    for (logic [31:0] off = 0; off < r; off += 32'(MAXB)) begin
      b.addr = addr + 64'(off);
      b.len  = (r - off > 32'(MAXB)) ? 32'(MAXB) : r - off;
      b.tag  = tag;
      exp_q.push_back(b);
    end
  endfunction

  task automatic obs_clear();
    obs_n = 0;
    obs_first_addr = '0; obs_last_addr = '0;
    obs_first_len = '0;  obs_last_len = '0;
    a_rx.delete();
    b_rx.delete();
  endtask

  task automatic cyc();
    bit idle, ga, gb, mv, has, to_a, em_r;
    logic [7:0] head;
    @(negedge clk);
    idle = (exp_q.size() == 0);
    ga   = idle && a_cmd_valid && (!b_cmd_valid || mdl_last_b);
    gb   = idle && b_cmd_valid && (!a_cmd_valid || !mdl_last_b);
    chk_b("a_cmd_ready", a_cmd_ready, ga);
    chk_b("b_cmd_ready", b_cmd_ready, gb);
    mv = !idle && (tag_q.size() < DEPTH);
    chk_b("m_cmd_valid", m_cmd_valid, mv);
    if (mv) begin
      chk("m_cmd_address", m_cmd_address, exp_q[0].addr);
      chk("m_cmd_length", 64'(m_cmd_length), 64'(exp_q[0].len));
    end
    has  = (tag_q.size() > 0);
    head = has ? tag_q[0] : 8'h00;
    to_a = has && (head == TAG_A);
    em_r = has && (to_a ? a_rd_data_tready : b_rd_data_tready);
    chk_b("m_rd_data_tready", m_rd_data_tready, em_r);
    chk_b("a_rd_data_tvalid", a_rd_data_tvalid, to_a && m_rd_data_tvalid);
    chk_b("b_rd_data_tvalid", b_rd_data_tvalid, has && !to_a && m_rd_data_tvalid);
    if (has && m_rd_data_tvalid) begin
      chk_b("rd_tdata", to_a ? (a_rd_data_tdata == m_rd_data_tdata)
                             : (b_rd_data_tdata == m_rd_data_tdata), 1'b1);
      chk("rd_tkeep", to_a ? a_rd_data_tkeep : b_rd_data_tkeep, m_rd_data_tkeep);
      chk_b("rd_tlast", to_a ? a_rd_data_tlast : b_rd_data_tlast, m_rd_data_tlast);
    end
    chk("outstanding", 64'(outstanding), 64'(tag_q.size()));
    chk_b("err_len", err_len, mdl_err);

    if (m_cmd_valid && m_cmd_ready) begin
      if (obs_n == 0) begin
        obs_first_addr = m_cmd_address;
        obs_first_len  = m_cmd_length;
      end
      obs_last_addr = m_cmd_address;
      obs_last_len  = m_cmd_length;
      obs_n++;
    end
    if (a_rd_data_tvalid && a_rd_data_tready) a_rx.push_back(a_rd_data_tdata);
    if (b_rd_data_tvalid && b_rd_data_tready) b_rx.push_back(b_rd_data_tdata);

    mdl_acc_a  = ga;
    mdl_acc_b  = gb;
    mdl_m_fire = em_r && m_rd_data_tvalid;
    if (mdl_m_fire && m_rd_data_tlast) void'(tag_q.pop_front());
    if (mv && m_cmd_ready) begin
      tag_q.push_back(exp_q[0].tag);
      void'(exp_q.pop_front());
    end
    if (ga) begin mdl_last_b = 1'b0; model_accept(a_cmd_address, a_cmd_length, TAG_A); end
    if (gb) begin mdl_last_b = 1'b1; model_accept(b_cmd_address, b_cmd_length, TAG_B); end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_cmd_valid = 0; a_cmd_address = '0; a_cmd_length = '0;
    b_cmd_valid = 0; b_cmd_address = '0; b_cmd_length = '0;
    m_cmd_ready = 0;
    m_rd_data_tvalid = 0; m_rd_data_tdata = '0; m_rd_data_tkeep = '1; m_rd_data_tlast = 0;
    a_rd_data_tready = 0; b_rd_data_tready = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    chk_b("rst_m_cmd_valid", m_cmd_valid, 1'b0);
    chk_b("rst_a_cmd_ready", a_cmd_ready, 1'b0);
    chk_b("rst_m_rd_tready", m_rd_data_tready, 1'b0);
    chk_b("rst_a_rd_tvalid", a_rd_data_tvalid, 1'b0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk_b("rst_err_len", err_len, 1'b0);
    rst_n = 1'b1;
    model_reset();
    obs_clear();
  endtask

  task automatic req(input bit src_b, input logic [63:0] addr, input logic [31:0] len);
    if (src_b) begin b_cmd_valid = 1; b_cmd_address = addr; b_cmd_length = len; end
    else       begin a_cmd_valid = 1; a_cmd_address = addr; a_cmd_length = len; end
  endtask

  typedef struct {
    bit          src_b;
    logic [63:0] addr;
    logic [31:0] len;
    int          n_cmd;
    logic [63:0] last_addr;
    logic [31:0] first_len;
    logic [31:0] last_len;
    bit          err;
  } vec_t;

  vec_t vecs[8];
  logic [511:0] d1, d2;
  logic [511:0] beats[4];
  bit stall_tbl[8];

  initial begin
    vecs[0] = '{0, 64'h1000, 32'd10240, 3, 64'h3000, 32'd4096, 32'd2048, 0};
    vecs[1] = '{1, 64'h0, 32'd64, 1, 64'h0, 32'd64, 32'd64, 0};
    vecs[2] = '{0, 64'h40, 32'd100, 1, 64'h40, 32'd64, 32'd64, 1};
    vecs[3] = '{1, 64'h80, 32'd32, 0, 64'h0, 32'd0, 32'd0, 1};
    vecs[4] = '{0, 64'h0, 32'd0, 0, 64'h0, 32'd0, 32'd0, 0};
    vecs[5] = '{1, 64'h10000, 32'd4096, 1, 64'h10000, 32'd4096, 32'd4096, 0};
    vecs[6] = '{0, 64'h5000, 32'd8263, 3, 64'h7000, 32'd4096, 32'd64, 1};
    vecs[7] = '{1, 64'hFFFF_FFFF_FFFF_F000, 32'd4160, 2, 64'h0, 32'd4096, 32'd64, 0};
    model_reset();
    obs_clear();

    // Region vectors: each from reset, memory accepting, no data returned.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      req(vecs[v].src_b, vecs[v].addr, vecs[v].len);
      m_cmd_ready = 1;
      cyc();
      a_cmd_valid = 0; b_cmd_valid = 0;
      for (int i = 0; i < 30; i++) cyc();
      chk($sformatf("v%0d_n_cmd", v), 64'(obs_n), 64'(vecs[v].n_cmd));
      chk($sformatf("v%0d_outstanding", v), 64'(outstanding), 64'(vecs[v].n_cmd));
      chk_b($sformatf("v%0d_err_len", v), err_len, vecs[v].err);
      if (vecs[v].n_cmd > 0) begin
        chk($sformatf("v%0d_first_addr", v), obs_first_addr, vecs[v].addr);
        chk($sformatf("v%0d_first_len", v), 64'(obs_first_len), 64'(vecs[v].first_len));
        chk($sformatf("v%0d_last_addr", v), obs_last_addr, vecs[v].last_addr);
        chk($sformatf("v%0d_last_len", v), 64'(obs_last_len), 64'(vecs[v].last_len));
      end
    end

    // Simultaneous A and B after reset: A first, then B; data routed in issue order.
    do_reset();
    req(0, 64'h100, 32'd64);
    req(1, 64'h200, 32'd64);
    m_cmd_ready = 1;
    cyc();
    a_cmd_valid = 0;
    for (int i = 0; i < 8 && b_cmd_valid; i++) begin
      cyc();
      if (mdl_acc_b) b_cmd_valid = 0;
    end
    chk_b("s1_b_accepted", b_cmd_valid, 1'b0);
    b_cmd_valid = 0;
    for (int i = 0; i < 3; i++) cyc();
    chk("s1_first_addr", obs_first_addr, 64'h100);
    chk("s1_last_addr", obs_last_addr, 64'h200);
    d1 = {16{32'hA1A1_0001}};
    d2 = {16{32'hB2B2_0002}};
    a_rd_data_tready = 1; b_rd_data_tready = 1;
    m_rd_data_tvalid = 1; m_rd_data_tlast = 1; m_rd_data_tdata = d1;
    cyc();
    m_rd_data_tdata = d2;
    cyc();
    m_rd_data_tvalid = 0;
    cyc();
    chk("s1_a_count", 64'(a_rx.size()), 64'd1);
    chk_b("s1_a_data", (a_rx.size() > 0) && (a_rx[0] == d1), 1'b1);
    chk("s1_b_count", 64'(b_rx.size()), 64'd1);
    chk_b("s1_b_data", (b_rx.size() > 0) && (b_rx[0] == d2), 1'b1);

    // Tag FIFO fills at 16; one returned burst lets the 17th command out.
    do_reset();
    req(0, 64'h0, 32'd81920);
    m_cmd_ready = 1;
    cyc();
    a_cmd_valid = 0;
    for (int i = 0; i < 30; i++) cyc();
    chk("s2_n_cmd_full", 64'(obs_n), 64'd16);
    chk_b("s2_m_cmd_valid_full", m_cmd_valid, 1'b0);
    chk("s2_outstanding_full", 64'(outstanding), 64'd16);
    a_rd_data_tready = 1;
    m_rd_data_tvalid = 1; m_rd_data_tlast = 1; m_rd_data_tdata = '1;
    cyc();
    m_rd_data_tvalid = 0; m_rd_data_tlast = 0;
    cyc();
    cyc();
    chk("s2_n_cmd_after_pop", 64'(obs_n), 64'd17);
    chk("s2_next_addr", obs_last_addr, 64'h10000);

    // 4-beat burst with destination stalls: no beat lost or duplicated.
    m_cmd_ready = 0;
    a_rx.delete();
    for (int k = 0; k < 4; k++) beats[k] = {16{32'hC0DE_0000 + 32'(k)}};
    stall_tbl = '{1, 0, 0, 1, 0, 1, 1, 1};
    begin
      int k;
      k = 0;
      for (int c = 0; c < 8; c++) begin
        m_rd_data_tvalid = (k < 4);
        m_rd_data_tdata  = beats[k % 4];
        m_rd_data_tlast  = (k == 3);
        a_rd_data_tready = stall_tbl[c];
        b_rd_data_tready = 1;
        cyc();
        if (mdl_m_fire) k++;
      end
    end
    m_rd_data_tvalid = 0;
    chk("s3_beat_count", 64'(a_rx.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      chk_b($sformatf("s3_beat%0d", k), (a_rx.size() > k) && (a_rx[k] == beats[k]), 1'b1);
    chk("s3_b_beats", 64'(b_rx.size()), 64'd0);
    chk("s3_outstanding", 64'(outstanding), 64'd15);

    // Reset in the middle of issuing with two bursts outstanding.
    do_reset();
    req(0, 64'h8000, 32'd16384);
    m_cmd_ready = 1;
    cyc();
    a_cmd_valid = 0;
    cyc();
    cyc();
    m_cmd_ready = 0;
    cyc();
    chk("s4_outstanding_pre", 64'(outstanding), 64'd2);
    rst_n = 0;
    #1;
    chk("s4_rst_outstanding", 64'(outstanding), 64'd0);
    chk_b("s4_rst_m_cmd_valid", m_cmd_valid, 1'b0);
    chk_b("s4_rst_m_rd_tready", m_rd_data_tready, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    obs_clear();
    req(0, 64'h9000, 32'd64);
    m_cmd_ready = 1;
    cyc();
    a_cmd_valid = 0;
    cyc();
    cyc();
    chk("s4_post_n_cmd", 64'(obs_n), 64'd1);
    chk("s4_post_addr", obs_first_addr, 64'h9000);
    chk("s4_post_outstanding", 64'(outstanding), 64'd1);

    // Sticky length error: 100 bytes then 32 bytes.
    do_reset();
    req(0, 64'h0, 32'd100);
    m_cmd_ready = 1;
    cyc();
    a_cmd_valid = 0;
    for (int i = 0; i < 3; i++) cyc();
    chk_b("s5_err_after_100", err_len, 1'b1);
    req(1, 64'h40, 32'd32);
    cyc();
    b_cmd_valid = 0;
    for (int i = 0; i < 3; i++) cyc();
    chk_b("s5_err_after_32", err_len, 1'b1);
    chk("s5_n_cmd", 64'(obs_n), 64'd1);
    chk("s5_len", 64'(obs_first_len), 64'd64);

    // Random traffic against the reference model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int s = 0; s < 2; s++) begin
        if (!(s == 0 ? a_cmd_valid : b_cmd_valid) && ($urandom % 4 == 0)) begin
          logic [31:0] len;
          case ($urandom % 4)
            0:       len = 32'($urandom_range(0, 200));
            1:       len = 32'(64 * $urandom_range(1, 8));
            2:       len = 32'(64 * $urandom_range(60, 130));
            default: len = 32'(4096 * $urandom_range(1, 3));
          endcase
          req(s == 1, {$urandom, $urandom}, len);
        end
      end
      m_cmd_ready      = ($urandom % 4 != 0);
      m_rd_data_tvalid = ($urandom % 2 == 0);
      m_rd_data_tlast  = ($urandom % 3 == 0);
      for (int w = 0; w < 16; w++) m_rd_data_tdata[w*32 +: 32] = $urandom;
      m_rd_data_tkeep  = {$urandom, $urandom};
      a_rd_data_tready = ($urandom % 10 < 7);
      b_rd_data_tready = ($urandom % 10 < 7);
      cyc();
      if (mdl_acc_a) a_cmd_valid = 0;
      if (mdl_acc_b) b_cmd_valid = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sgd_rd_cmd_arbiter.md
# sgd_rd_cmd_arbiter

Shares the single memory read-command channel between the training-dataset reader (A) and the label/bias reader (B) of the SGD engine. Accepts whole-region read requests from both, arbitrates round-robin, splits each region into bounded bursts, and records a source tag (0x0a for A, 0x0b for B) per issued burst. Routes the returned 512-bit read-data stream back to the correct requester in issue order. Sits between the SGD engine's A/B fetch logic and the memory read interface.

## Interface
- MAX_BURST_BYTES, 4096, maximum length of one issued command; power of two, multiple of 64
- TAG_FIFO_DEPTH, 16, outstanding bursts tracked; power of two
- clk  in  1  single clock
- rst_n  in  1  reset; asynchronous, active-low
- a_cmd  axis_mem_cmd.slave  64+32  region request from A (address, length in bytes)
- b_cmd  axis_mem_cmd.slave  64+32  region request from B
- m_cmd  axis_mem_cmd.master  64+32  burst command to memory
- m_rd_data  axi_stream.slave  512  read data from memory; last marks end of one burst
- a_rd_data  axi_stream.master  512  data routed to A
- b_rd_data  axi_stream.master  512  data routed to B
- outstanding  out  5  bursts issued but not yet fully returned (= tag FIFO occupancy)
- err_len  out  1  sticky: a request length not a multiple of 64 was seen

## Operation
- Issuer FSM: IDLE, ISSUE.
- IDLE: if exactly one of a_cmd.valid/b_cmd.valid, grant it; if both, grant the one not granted last (after reset A wins first). Grant = assert that slave's ready for one cycle, latch address/length into cur_addr (64b)/remaining (32b) and cur_tag.
- Length 0: accepted, no burst issued, stay IDLE (round-robin pointer still updates).
- Length not multiple of 64: set err_len, round remaining down to multiple of 64; if result 0, treat as length 0.
- ISSUE: m_cmd.valid=1, m_cmd.address=cur_addr, m_cmd.length=min(remaining, MAX_BURST_BYTES). m_cmd.valid only asserted when tag FIFO not full. On m_cmd handshake: push cur_tag, cur_addr+=length, remaining-=length; if remaining reaches 0, go IDLE.
- No crossing-boundary alignment is performed; bursts are contiguous from the request address.
- Router: while tag FIFO non-empty, head tag selects destination; m_rd_data.valid/data/keep/last pass combinationally to that output, its ready returns to m_rd_data.ready; other output valid=0. Handshake of a beat with last=1 pops the FIFO. FIFO empty: m_rd_data.ready=0, both outputs invalid.
- Push and pop in the same cycle: occupancy unchanged; push when full never occurs (gated); FIFO empty with push: head valid from next cycle.
- outstanding = FIFO occupancy, 0..TAG_FIFO_DEPTH.

## Timing
- Reset (async assert, sync deassert assumed upstream): FSM IDLE, all valid/ready outputs 0, outstanding 0, err_len 0, RR pointer favours A, FIFO empty.
- Request accept: ready high the cycle IDLE grants; first m_cmd.valid the following cycle (1-cycle latency).
- Back-to-back bursts of one region: one per cycle when m_cmd.ready held high and FIFO not full.
- After final burst handshake, IDLE for one cycle before next grant (minimum 2 cycles between request accepts).
- m_cmd payload stable while valid and not ready.
- Router: zero latency, no added register stage; data beats only stall on destination ready.

## Structure
- Package sgd_rd_pkg: MEM_RD_A_TAG=8'h0a, MEM_RD_B_TAG=8'h0b, CL_BYTES=64, default MAX_BURST_BYTES, state enum typedef.
- One sub-module: sgd_tag_fifo (synchronous FIFO, 8-bit entries, depth TAG_FIFO_DEPTH, count output, async active-low reset).

## Test plan
- A requests addr 0x1000 len 10240, m_cmd.ready=1 -> commands (0x1000,4096),(0x2000,4096),(0x3000,2048); three A tags pushed; outstanding=3.
- A and B valid same cycle after reset, len 64 each -> A granted first, B next; returned two bursts (1 beat each) appear on a_rd_data then b_rd_data.
- m_cmd.ready=1, memory never returns data, A len 20×4096 -> exactly 16 commands issued, m_cmd.valid drops, outstanding=16; return one burst -> 17th command issues.
- Request len 100 -> err_len=1, one command length 64; request len 32 -> err_len stays 1, accepted, no command.
- a_rd_data.ready=0 mid-burst with 4-beat burst -> m_rd_data.ready=0, no beat lost or duplicated; b_rd_data.valid stays 0.
- rst_n asserted while ISSUE with 2 bursts outstanding -> all outputs 0, outstanding=0 immediately; next request handled from clean state.
